// File: rtl/handshake_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_fifo_buffer
//  Description : Opaque elastic FIFO for valid/ready dataflow channels.
//                Stores up to NUM_SLOTS tokens in arrival order and presents
//                the oldest one on a registered output channel. Neither
//                valid nor ready has a combinational path through the
//                buffer, so it cuts timing between producer and consumer.
//
//  Parameters  : DATA_WIDTH  token payload width in bits (>= 1)
//                NUM_SLOTS   storage depth in tokens (>= 2, any value)
//
//  Ports       : clk         rising-edge clock
//                rst         asynchronous, active-high reset
//                ins         input token payload
//                ins_valid   producer offers a token
//                ins_ready   buffer can accept a token
//                outs        oldest stored token (stale when empty)
//                outs_valid  buffer holds at least one token
//                outs_ready  consumer accepts the token
//
//  Revision    : 1.0  initial release
// ============================================================================
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    // Explicit wrap index: pointers must not rely on natural overflow,
    // since NUM_SLOTS need not be a power of two.
    localparam logic [PTR_W-1:0] c_last_slot = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] c_full_cnt  = CNT_W'(NUM_SLOTS);
    localparam logic [CNT_W-1:0] c_one_cnt   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_one_ptr   = PTR_W'(1);

    logic [DATA_WIDTH-1:0] r_slot [NUM_SLOTS];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_push;
    logic                  w_pop;
    logic [PTR_W-1:0]      w_head_next;
    logic [PTR_W-1:0]      w_tail_next;

    // ------------------------------------------------------------------
    // Output decode. ins_ready depends only on stored occupancy (and rst),
    // never on outs_ready: a pop while full frees the slot for the next
    // cycle, not the current one.
    // ------------------------------------------------------------------
    assign ins_ready  = (r_count != c_full_cnt) && !rst;
    assign outs_valid = (r_count != '0);
    assign outs       = r_slot[r_head];

    assign w_push = ins_valid && ins_ready;
    assign w_pop  = outs_valid && outs_ready;

    always_comb begin
        w_head_next = r_head;
        w_tail_next = r_tail;
        if (w_pop) begin
            w_head_next = (r_head == c_last_slot) ? '0 : r_head + c_one_ptr;
        end
        if (w_push) begin
            w_tail_next = (r_tail == c_last_slot) ? '0 : r_tail + c_one_ptr;
        end
    end

    // ------------------------------------------------------------------
    // Pointer and occupancy registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head <= w_head_next;
            r_tail <= w_tail_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one_cnt;
                2'b01:   r_count <= r_count - c_one_cnt;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage array. Each slot is its own register so the reset clear and
    // the tail-addressed write stay simple per-slot enables.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_slot[g] <= '0;
                end else if (w_push && (r_tail == PTR_W'(g))) begin
                    r_slot[g] <= ins;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_handshake_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_fifo_buffer
//  Description : Directed scoreboard bench for handshake_fifo_buffer.
//                Instance a: NUM_SLOTS = 4, instance b: NUM_SLOTS = 3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_handshake_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_ins, a_outs, b_ins, b_outs;
    logic        a_ins_valid, a_ins_ready, a_outs_valid, a_outs_ready;
    logic        b_ins_valid, b_ins_ready, b_outs_valid, b_outs_ready;

    handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
        .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready)
    );

    handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
        .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready)
    );

    int          compares = 0;
    int          fails    = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          a_pushes = 0, a_pops = 0, b_pushes = 0, b_pops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; checks
    // outputs against the model, records handshakes, advances one cycle.
    task automatic step_a(input string tag);
        #1;
        if (rst) begin
            check({tag, " rst ins_ready"},  32'(a_ins_ready),  32'd0);
            check({tag, " rst outs_valid"}, 32'(a_outs_valid), 32'd0);
            check({tag, " rst outs"},       a_outs,            32'd0);
        end else begin
            check({tag, " a ins_ready"},  32'(a_ins_ready),  32'(qa.size() != 4));
            check({tag, " a outs_valid"}, 32'(a_outs_valid), 32'(qa.size() != 0));
            if (qa.size() != 0) check({tag, " a outs"}, a_outs, qa[0]);
            if (a_outs_valid && a_outs_ready && qa.size() != 0) begin
                qa.delete(0);
                a_pops++;
            end
            if (a_ins_valid && a_ins_ready) begin
                qa.push_back(a_ins);
                a_pushes++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_b(input string tag);
        #1;
        check({tag, " b ins_ready"},  32'(b_ins_ready),  32'(qb.size() != 3));
        check({tag, " b outs_valid"}, 32'(b_outs_valid), 32'(qb.size() != 0));
        if (qb.size() != 0) check({tag, " b outs"}, b_outs, qb[0]);
        if (b_outs_valid && b_outs_ready && qb.size() != 0) begin
            qb.delete(0);
            b_pops++;
        end
        if (b_ins_valid && b_ins_ready) begin
            qb.push_back(b_ins);
            b_pushes++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int cyc;
        int prev;

        a_ins = 32'hDEADBEEF; a_ins_valid = 1'b1; a_outs_ready = 1'b0;
        b_ins = 32'hDEADBEEF; b_ins_valid = 1'b1; b_outs_ready = 1'b0;

        // Reset held three cycles with a token offered.
        @(negedge clk);
        for (int i = 0; i < 3; i++) step_a("reset");
        rst = 1'b0;
        a_ins_valid = 1'b0; b_ins_valid = 1'b0;
        step_a("post_reset");
        step_a("post_reset");
        check("post_reset b valid", 32'(b_outs_valid), 32'd0);

        // Fill to capacity with backpressure, then offer a fifth token.
        a_ins_valid = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            a_ins = 32'(v);
            step_a("fill");
        end
        a_ins = 32'h5;
        step_a("fill_rejected");
        check("fill pushes", 32'(a_pushes), 32'd4);

        // Drain on consecutive cycles.
        a_ins_valid = 1'b0; a_outs_ready = 1'b1;
        prev = a_pops;
        for (int i = 0; i < 5; i++) step_a("drain");
        check("drain pops", 32'(a_pops - prev), 32'd4);

        // Full with simultaneous pop: pop-only first, then push and pop.
        a_outs_ready = 1'b0; a_ins_valid = 1'b1;
        for (int v = 8'h11; v <= 8'h14; v++) begin
            a_ins = 32'(v);
            step_a("refill");
        end
        a_outs_ready = 1'b1; a_ins = 32'h15;
        prev = a_pushes;
        step_a("full_pop_only");
        check("full_pop_only no push", 32'(a_pushes - prev), 32'd0);
        step_a("full_push_pop");
        check("full_push_pop push", 32'(a_pushes - prev), 32'd1);
        a_ins_valid = 1'b0;
        for (int i = 0; i < 4; i++) step_a("refill_drain");
        check("refill_drain empty", 32'(qa.size()), 32'd0);

        // Streaming 0..99 with both sides always willing.
        base = a_pushes; prev = a_pops; cyc = 0;
        a_outs_ready = 1'b1;
        while ((a_pops - prev) < 100 && cyc < 400) begin
            a_ins       = 32'(a_pushes - base);
            a_ins_valid = ((a_pushes - base) < 100);
            step_a("stream");
            cyc++;
        end
        check("stream pops", 32'(a_pops - prev), 32'd100);
        check("stream cycles", 32'(cyc), 32'd101);
        a_ins_valid = 1'b0;

        // Wrap on the 3-slot instance with random gaps and backpressure.
        cyc = 0;
        b_ins_valid = 1'b0;
        while (b_pops < 10 && cyc < 1000) begin
            prev = b_pushes;
            b_ins        = 32'h0A0 + 32'(b_pushes);
            b_outs_ready = 1'($urandom_range(0, 1));
            step_b("wrap");
            // Hold an offered token until it is taken.
            if (!b_ins_valid || b_pushes != prev)
                b_ins_valid = (b_pushes < 10) && 1'($urandom_range(0, 1));
            cyc++;
        end
        check("wrap pops", 32'(b_pops), 32'd10);
        b_ins_valid = 1'b0; b_outs_ready = 1'b0;

        // Reset asserted between edges with two tokens stored.
        a_outs_ready = 1'b0; a_ins_valid = 1'b1;
        a_ins = 32'h55; step_a("pre_mid_reset");
        a_ins = 32'h66; step_a("pre_mid_reset");
        a_ins_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_reset outs_valid async", 32'(a_outs_valid), 32'd0);
        check("mid_reset ins_ready", 32'(a_ins_ready), 32'd0);
        check("mid_reset outs", a_outs, 32'd0);
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        step_a("after_mid_reset");
        a_ins_valid = 1'b1; a_outs_ready = 1'b1;
        for (int v = 8'h70; v < 8'h74; v++) begin
            a_ins = 32'(v);
            step_a("after_mid_reset_stream");
        end
        a_ins_valid = 1'b0;
        for (int i = 0; i < 3; i++) step_a("after_mid_reset_drain");
        check("after_mid_reset empty", 32'(qa.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/handshake_fifo_buffer.md
# handshake_fifo_buffer

Opaque elastic FIFO buffer for dataflow channels; it decouples a producer such as a constant or arithmetic unit from its consumer. It accepts tokens on a valid/ready input channel, stores up to NUM_SLOTS of them in order, and presents the oldest on a registered output channel. There is no combinational path from input to output in either direction (valid or ready), so the buffer cuts timing paths between stages.

## Interface
- DATA_WIDTH, 32, token payload width in bits (≥1)
- NUM_SLOTS, 4, storage depth in tokens (≥2; need not be a power of two)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ins  input  DATA_WIDTH  input token payload
- ins_valid  input  1  producer offers a token
- ins_ready  output  1  buffer can accept a token
- outs  output  DATA_WIDTH  oldest stored token
- outs_valid  output  1  buffer holds at least one token
- outs_ready  input  1  consumer accepts the token

## Operation
- Storage: NUM_SLOTS × DATA_WIDTH register array, plus:
  - head pointer (read index) and tail pointer (write index), each ranging 0..NUM_SLOTS-1;
  - occupancy counter, $clog2(NUM_SLOTS+1) bits, ranging 0..NUM_SLOTS.
- Push when ins_valid && ins_ready:
  - write ins to slot[tail];
  - tail wraps from NUM_SLOTS-1 to 0; otherwise it increments.
- Pop when outs_valid && outs_ready:
  - head wraps from NUM_SLOTS-1 to 0; otherwise it increments.
- Occupancy update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop.
- Output decode:
  - ins_ready = (count != NUM_SLOTS) && !rst;
  - outs_valid = (count != 0);
  - outs = slot[head].
- ins_ready does not depend on outs_ready. When full, a same-cycle pop does not enable a push; the freed slot is offered on the next cycle.
- outs_valid does not depend on ins_valid. A token written into an empty buffer appears one cycle later (no bypass).
- outs is stable while outs_valid && !outs_ready (AXI-style hold). The upstream producer must hold ins and ins_valid until ins_ready.
- When empty, outs shows slot[head], which is stale data. Consumers must ignore it.
- Reset (asynchronous, effective immediately on rst rising):
  - head, tail and count clear to 0;
  - all slots clear to 0;
  - outs_valid = 0, outs = 0, ins_ready = 0 while rst is high.
- Reset asserted mid-operation discards all stored tokens. No partial handshake is completed in the reset cycle.
- After rst falls, ins_ready = 1 combinationally. The first push can occur on the first clock edge with rst low.

## Timing
- Latency: input handshake at edge N gives outs_valid = 1 after edge N, when the buffer was empty before.
- Throughput: one token per cycle in steady state when 0 < count < NUM_SLOTS, with ins_valid and outs_ready held high.
- Full (count = NUM_SLOTS): ins_ready = 0. Throughput drops to one token every two cycles only if the buffer sits full while the consumer and producer alternate.
- Empty (count = 0): outs_valid = 0. An asserted outs_ready has no effect.
- Simultaneous push and pop at 0 < count < NUM_SLOTS: count is unchanged and both pointers advance.
- Pointer wrap must be correct for non-power-of-two NUM_SLOTS: compare explicitly against NUM_SLOTS-1, never rely on natural overflow.
- All state changes occur on the rising edge of clk, except the asynchronous reset.

## Test plan
- Reset: hold rst high for 3 cycles with ins_valid = 1 and ins = 0xDEADBEEF -> outs_valid = 0, ins_ready = 0, outs = 0. After release, ins_ready = 1 and nothing is stored.
- Fill/drain, NUM_SLOTS = 4: push 0x1, 0x2, 0x3, 0x4 with outs_ready = 0 -> ins_ready = 0 after the 4th push and a 5th token (0x5) is not accepted. Then set outs_ready = 1 -> outs shows 0x1, 0x2, 0x3, 0x4 on consecutive cycles, then outs_valid = 0.
- Streaming: ins_valid = 1 and outs_ready = 1 continuously with ins counting 0..99 -> outs delivers 0..99 in order, one per cycle after a 1-cycle initial latency, with no loss or duplication.
- Wrap, NUM_SLOTS = 3: push and pop alternately 10 tokens (0xA0..0xA9) with random backpressure on outs_ready (~50%) and random gaps on ins_valid -> output order is exactly 0xA0..0xA9, and count never exceeds 3.
- Full with simultaneous pop: at count = 4, set outs_ready = 1 and ins_valid = 1 -> first cycle pops only (count = 3), next cycle push and pop together (count stays 3).
- Reset mid-stream: at count = 2, assert rst between clock edges -> outs_valid falls immediately (asynchronously). After release, no old token (0x55, 0x66) ever appears on outs.
